// File: rtl/spmv_rowptr_times_gen.sv
// CSR row-pointer to per-row non-zero count (TIMES) stream converter with one output slot plus skid buffer.
// Optional build macro SPMV_SKIP_EMPTY_ROW_EN suppresses zero-length rows on the TIMES stream.
module spmv_rowptr_times_gen #(
  parameter int PTR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PTR_W-1:0] S_AXIS_PTR_tdata,
  input  logic             S_AXIS_PTR_tvalid,
  output logic             S_AXIS_PTR_tready,
  input  logic             S_AXIS_PTR_tlast,
  output logic [PTR_W-1:0] M_AXIS_TIMES_tdata,
  output logic             M_AXIS_TIMES_tvalid,
  input  logic             M_AXIS_TIMES_tready,
  output logic [CNT_W-1:0] rows_done,
  output logic             matrix_done,
  output logic             err_nonmono,
  output logic             err_short
);

`ifdef SPMV_SKIP_EMPTY_ROW_EN
  localparam bit SKIP_EMPTY = 1'b1;
`else
  localparam bit SKIP_EMPTY = 1'b0;
`endif

  typedef enum logic {FIRST, RUN} state_t;
  state_t state, state_nxt;

  logic             in_rdy, in_rdy_nxt;
  logic             acc_in, run_acc;
  logic [PTR_W-1:0] prev_ptr;

  // stage p0: difference computed combinationally on the accepted pointer
  logic [PTR_W-1:0] diff_p0, times_p0;
  logic             nonmono_p0, vld_p0, drop_p0;

  // stage p1: registered output slot; skid holds one overflow beat
  logic [PTR_W-1:0] times_p1, times_p1_nxt, skid_data, skid_data_nxt;
  logic             vld_p1, vld_p1_nxt, last_p1, last_p1_nxt;
  logic             skid_vld, skid_vld_nxt, skid_last, skid_last_nxt;
  logic             slot_free;

  assign S_AXIS_PTR_tready   = in_rdy;
  assign M_AXIS_TIMES_tdata  = times_p1;
  assign M_AXIS_TIMES_tvalid = vld_p1;

  assign acc_in     = S_AXIS_PTR_tvalid & in_rdy;
  assign run_acc    = acc_in & (state == RUN);
  assign diff_p0    = S_AXIS_PTR_tdata - prev_ptr;
  assign nonmono_p0 = S_AXIS_PTR_tdata < prev_ptr;
  assign times_p0   = nonmono_p0 ? '0 : diff_p0;
  assign drop_p0    = run_acc & SKIP_EMPTY & (diff_p0 == '0);
  assign vld_p0     = run_acc & ~drop_p0;

  assign slot_free   = ~vld_p1 | M_AXIS_TIMES_tready;
  assign matrix_done = (vld_p1 & M_AXIS_TIMES_tready & last_p1) | (drop_p0 & S_AXIS_PTR_tlast);

  always_comb begin
    state_nxt = state;
    case (state)
      FIRST:   if (acc_in && !S_AXIS_PTR_tlast) state_nxt = RUN;
      RUN:     if (acc_in && S_AXIS_PTR_tlast)  state_nxt = FIRST;
      default: state_nxt = FIRST;
    endcase
  end

  always_comb begin
    times_p1_nxt  = times_p1;
    vld_p1_nxt    = vld_p1;
    last_p1_nxt   = last_p1;
    skid_data_nxt = skid_data;
    skid_vld_nxt  = skid_vld;
    skid_last_nxt = skid_last;
    if (slot_free) begin
      if (skid_vld) begin
        times_p1_nxt  = skid_data;
        vld_p1_nxt    = 1'b1;
        last_p1_nxt   = skid_last;
        skid_vld_nxt  = vld_p0;
        skid_data_nxt = times_p0;
        skid_last_nxt = S_AXIS_PTR_tlast;
      end else begin
        vld_p1_nxt   = vld_p0;
        times_p1_nxt = vld_p0 ? times_p0 : times_p1;
        last_p1_nxt  = vld_p0 & S_AXIS_PTR_tlast;
      end
    end else if (vld_p0) begin
      skid_vld_nxt  = 1'b1;
      skid_data_nxt = times_p0;
      skid_last_nxt = S_AXIS_PTR_tlast;
    end
    in_rdy_nxt = ~skid_vld_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FIRST;
      in_rdy    <= 1'b0;
      prev_ptr  <= '0;
      times_p1  <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      skid_data <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_rdy    <= in_rdy_nxt;
      if (acc_in) prev_ptr <= S_AXIS_PTR_tdata;
      times_p1  <= times_p1_nxt;
      vld_p1    <= vld_p1_nxt;
      last_p1   <= last_p1_nxt;
      skid_data <= skid_data_nxt;
      skid_vld  <= skid_vld_nxt;
      skid_last <= skid_last_nxt;
    end
  end

  // status: row counter restarts after each matrix completes, error flags are sticky
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_done   <= '0;
      err_nonmono <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      if (matrix_done)
        rows_done <= (run_acc && !(drop_p0 && S_AXIS_PTR_tlast)) ? CNT_W'(1) : '0;
      else if (run_acc && rows_done != {CNT_W{1'b1}})
        rows_done <= rows_done + CNT_W'(1);
      if (run_acc && nonmono_p0)
        err_nonmono <= 1'b1;
      if (acc_in && state == FIRST && S_AXIS_PTR_tlast)
        err_short <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spmv_rowptr_times_gen.sv
// Directed bench for spmv_rowptr_times_gen: hand-computed TIMES sequences, status flags and reset behaviour.
module tb_spmv_rowptr_times_gen;
  localparam int PTR_W = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic [PTR_W-1:0] s_tdata;
  logic             s_tvalid, s_tready, s_tlast;
  logic [PTR_W-1:0] m_tdata;
  logic             m_tvalid, m_tready;
  logic [CNT_W-1:0] rows_done;
  logic             matrix_done, err_nonmono, err_short;

  always #5 clk = ~clk;

  spmv_rowptr_times_gen #(.PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .S_AXIS_PTR_tdata    (s_tdata),
    .S_AXIS_PTR_tvalid   (s_tvalid),
    .S_AXIS_PTR_tready   (s_tready),
    .S_AXIS_PTR_tlast    (s_tlast),
    .M_AXIS_TIMES_tdata  (m_tdata),
    .M_AXIS_TIMES_tvalid (m_tvalid),
    .M_AXIS_TIMES_tready (m_tready),
    .rows_done           (rows_done),
    .matrix_done         (matrix_done),
    .err_nonmono         (err_nonmono),
    .err_short           (err_short)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [PTR_W-1:0] got_q[$];
  logic [PTR_W-1:0] exp_q[$];
  int               md_cnt = 0;
  logic [CNT_W-1:0] md_rows;
  logic [PTR_W-1:0] md_data;

  // downstream monitor: capture beats, matrix_done context, and hold stability during stalls
  initial begin
    logic             prev_stall;
    logic [PTR_W-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_vld", m_tvalid, 1);
          chk("hold_data", m_tdata, prev_data);
        end
        if (m_tvalid && m_tready) got_q.push_back(m_tdata);
        if (matrix_done) begin
          md_cnt++;
          md_rows = rows_done;
          md_data = m_tdata;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
    end
  end

  logic tog_en  = 1'b0;
  logic rdy_lvl = 1'b1;

  // downstream ready: fixed level or 1,0,0,1 repeating pattern
  initial begin
    int tog_i;
    tog_i    = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        m_tready = (tog_i % 4 == 0) || (tog_i % 4 == 3);
        tog_i++;
      end else begin
        m_tready = rdy_lvl;
      end
    end
  end

  task automatic send(input logic [PTR_W-1:0] p, input logic l);
    s_tdata  = p;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got_q.delete();
    md_cnt = 0;
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, "_beat"}, got_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_rows_done", rows_done, 0);
    chk("rst_matrix_done", matrix_done, 0);
    chk("rst_err_nonmono", err_nonmono, 0);
    chk("rst_err_short", err_short, 0);
    rstn = 1'b1;
    #1;
    chk("rdy_before_edge", s_tready, 0);
    @(posedge clk);
    #1;
    chk("rdy_rise", s_tready, 1);

    // basic matrix, ready held high
    clr();
    send(0, 0);
    chk("t1_no_first_out", m_tvalid, 0);
    send(3, 0);
    chk("t1_lat_vld", m_tvalid, 1);
    chk("t1_lat_data", m_tdata, 3);
    send(3, 0);
    send(7, 0);
    send(12, 1);
    drain();
`ifdef SPMV_SKIP_EMPTY_ROW_EN
    exp_q = '{32'd3, 32'd4, 32'd5};
`else
    exp_q = '{32'd3, 32'd0, 32'd4, 32'd5};
`endif
    cmp_beats("t1");
    chk("t1_md_cnt", md_cnt, 1);
    chk("t1_md_rows", md_rows, 4);
    chk("t1_md_data", md_data, 5);
    chk("t1_rows_clr", rows_done, 0);

    // same matrix with downstream ready toggling
    clr();
    tog_en = 1'b1;
    send(0, 0);
    send(3, 0);
    send(3, 0);
    send(7, 0);
    send(12, 1);
    drain();
    tog_en = 1'b0;
    drain();
    cmp_beats("t2");
    chk("t2_md_cnt", md_cnt, 1);

    // back-to-back matrices
    clr();
    send(0, 0);
    send(2, 0);
    send(5, 1);
    send(10, 0);
    send(11, 1);
    drain();
    exp_q = '{32'd2, 32'd3, 32'd1};
    cmp_beats("t3");
    chk("t3_md_cnt", md_cnt, 2);

    // non-monotonic pointer
    clr();
    send(0, 0);
    send(8, 0);
    chk("t4_nonmono_pre", err_nonmono, 0);
    send(4, 0);
    chk("t4_nonmono_set", err_nonmono, 1);
    send(9, 1);
    drain();
    exp_q = '{32'd8, 32'd0, 32'd5};
    cmp_beats("t4");
    chk("t4_nonmono_sticky", err_nonmono, 1);
    chk("t4_short_clear", err_short, 0);

    // zero-row matrix
    do_reset();
    chk("t5_nonmono_rst", err_nonmono, 0);
    clr();
    send(7, 1);
    chk("t5_short_set", err_short, 1);
    drain();
    chk("t5_no_times", got_q.size(), 0);
    send(0, 0);
    send(1, 1);
    drain();
    exp_q = '{32'd1};
    cmp_beats("t5");
    chk("t5_short_sticky", err_short, 1);

    // reset while an output beat is stalled
    do_reset();
    clr();
    rdy_lvl = 1'b0;
    @(posedge clk);
    #1;
    send(0, 0);
    send(4, 0);
    chk("t6_stall_vld", m_tvalid, 1);
    chk("t6_stall_data", m_tdata, 4);
    rstn = 1'b0;
    #1;
    chk("t6_rst_vld", m_tvalid, 0);
    chk("t6_rst_data", m_tdata, 0);
    chk("t6_rst_rdy", s_tready, 0);
    chk("t6_rst_rows", rows_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn    = 1'b1;
    rdy_lvl = 1'b1;
    clr();
    send(100, 0);
    send(104, 1);
    drain();
    exp_q = '{32'd4};
    cmp_beats("t6");
    chk("t6_md_cnt", md_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
